fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares one SYNC_FIFO write port among NUM_REQ producers. Each producer presents data with a req/ready handshake. The arbiter grants one producer at a time for bursts of up to BURST_MAX beats and drives the FIFO's cs/wr_en/data_in, stalling on full. It sits directly in front of SYNC_FIFO; the read side is untouched.

## Interface
- NUM_REQ, 4, number of producers (2..16)
- DATA_WIDTH, 32, data width; must match the FIFO instance
- BURST_MAX, 4, maximum accepted beats per grant (>=1)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- req  in  NUM_REQ  per-producer request; must be held with data stable until ready
- req_data  in  NUM_REQ*DATA_WIDTH  packed producer data; slice i belongs to producer i
- ready  out  NUM_REQ  one-hot-or-zero; beat of producer i accepted this cycle
- grant  out  NUM_REQ  registered one-hot-or-zero current owner
- fifo_full  in  1  FIFO full flag
- fifo_cs  out  1  FIFO chip select; equals fifo_wr_en (top level ORs in the read-side cs)
- fifo_wr_en  out  1  FIFO write enable
- fifo_data_in  out  DATA_WIDTH  FIFO write data, equals req_data slice of the owner

## Operation
- States: IDLE (grant==0) and BUSY (grant one-hot at g, beat counter cnt).
- Accept condition: state BUSY, req[g]=1, fifo_full=0, rst=0. Then ready[g]=1, fifo_wr_en=fifo_cs=1 and fifo_data_in=req_data[g]. Otherwise all three are 0; fifo_data_in is the owner slice, or 0 in IDLE.
- Pick: first i with req[i]=1, searching from rr_ptr upward modulo NUM_REQ.
- IDLE: if any req, then grant<=onehot(pick), cnt<=0 and go to BUSY; else stay.
- BUSY release occurs when either:
  - req[g]=0, or
  - an accept occurs with cnt==BURST_MAX-1.
- On release: rr_ptr<=(g+1) mod NUM_REQ. The pick is re-evaluated the same cycle, searching from g+1 and including g. If the pick is non-empty, grant moves to it with cnt<=0 and stays BUSY (no bubble); otherwise go to IDLE.
- BUSY with accept and no release: cnt<=cnt+1.
- BUSY stalled on full: cnt, grant and rr_ptr hold; the stall never counts toward the burst and never forces release.
- Only one producer is accepted per cycle; ready is never asserted for a non-owner.

## Timing
- Reset values (next edge with rst=1): state=IDLE, grant=0, cnt=0, rr_ptr=0.
- While rst=1, ready, fifo_wr_en and fifo_cs are 0 combinationally, regardless of state.
- Reset mid-burst discards the current grant; no write is issued in the reset cycle.
- Latency: req rising in IDLE gives grant on the next edge; the first accept is possible in that following cycle (1-cycle arbitration latency).
- Sustained throughput: 1 beat/cycle while not full, including across grant handoffs.
- ready, fifo_wr_en and fifo_data_in are combinational from the registered grant plus req/fifo_full; there is no path from req to grant within a cycle.
- The full flag is sampled in the same cycle as wr_en; FIFO occupancy is never exceeded.
- cnt width is clog2(BURST_MAX), minimum 1. rr_ptr width is clog2(NUM_REQ).

## Structure
- Shared package fifo_arb_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1);
  - clog2 function;
  - default parameter constants.
- One sub-module, rr_pick: purely combinational.
  - Inputs: req vector and start index.
  - Outputs: one-hot pick and valid.
  - Implement as a doubled-vector mask-and-priority search.
- Top module holds the state register, cnt, rr_ptr, grant, and the output muxing.

## Test plan
Use NUM_REQ=4, BURST_MAX=2 and DATA_WIDTH=32 throughout.
- Reset check: rst=1 for 2 cycles with req=4'b1111 -> grant=0, ready=0, fifo_wr_en=0 throughout; after release, grant=0001 on the first edge.
- Single producer: req[2] held with data 0x0000_0004 for 5 beats -> grant=0100 one cycle after req. Accepts occur in bursts of 2; at each release grant is re-picked to 0100, with no gap (5 writes in 5 consecutive cycles).
- Round-robin fairness: all 4 req held high -> grant sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001…; each fifo_data_in matches the owner's slice.
- Full stall: fifo_full=1 for 3 cycles mid-burst of producer 1 -> ready=0 and fifo_wr_en=0 during the stall, cnt holds, grant stays 0010, and the burst completes with 2 beats after full drops.
- Early drop: producer 0 drops req after 1 beat while req[3]=1 -> grant moves to 1000 on the next edge and rr_ptr=1.
- Reset mid-burst: assert rst during an accept cycle of producer 1 -> fifo_wr_en=0 in that cycle, and state returns to IDLE with rr_ptr=0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared definitions for the FIFO write-side arbiter.
//   arb_state_e     : arbiter state encoding (IDLE = no owner, BUSY = owner granted)
//   DEF_*           : default parameter values used by the arbiter modules
//   clog2()         : ceiling log2 with a floor of 1, so every counter/pointer
//                     has at least one bit
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BURST_MAX  = 4;

  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   [NUM_REQ-1:0] : request vector
//   start_i [PTR_W-1:0]   : index where the search begins (wraps modulo NUM_REQ)
//   pick_o  [NUM_REQ-1:0] : one-hot first requester at or after start_i, or 0
//   valid_o               : at least one request is present
// The request vector is duplicated side by side so the wrap-around search becomes
// a plain lowest-bit-first priority search over a window of NUM_REQ bits that
// starts at start_i.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   start_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  localparam int DBL = 2 * NUM_REQ;

  logic [DBL-1:0] dbl_req;
  logic [DBL-1:0] masked;
  logic [DBL-1:0] first;
  // seen[j] is set when some in-window request exists below bit j.
  logic [DBL:0]   seen;

  assign dbl_req = {req_i, req_i};
  assign seen[0] = 1'b0;

  generate
    for (genvar gi = 0; gi < DBL; gi++) begin : g_dbl
      localparam int J = gi;
      logic in_window;
      assign in_window   = (J >= int'(start_i)) && (J < int'(start_i) + NUM_REQ);
      assign masked[gi]  = dbl_req[gi] & in_window;
      assign first[gi]   = masked[gi] & ~seen[gi];
      assign seen[gi+1]  = seen[gi] | masked[gi];
    end
  endgenerate

  // Fold the doubled result back onto the producer indices.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fold
      assign pick_o[gi] = first[gi] | first[gi+NUM_REQ];
    end
  endgenerate

  // The window always spans NUM_REQ bits, so it covers every producer exactly once.
  assign valid_o = seen[DBL];

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one SYNC_FIFO write port among
// NUM_REQ producers, granting bursts of up to BURST_MAX beats.
//   clk, rst      : clock and synchronous active-high reset
//   req           : per-producer request, held with data until ready
//   req_data      : packed producer data, slice i belongs to producer i
//   ready         : one-hot-or-zero, beat of the owner accepted this cycle
//   grant         : registered one-hot-or-zero current owner
//   fifo_full     : FIFO full flag, sampled in the same cycle as the write
//   fifo_cs       : FIFO chip select (mirrors fifo_wr_en)
//   fifo_wr_en    : FIFO write enable
//   fifo_data_in  : owner's data slice, zero when no owner
// ready/fifo_wr_en/fifo_data_in depend only on registered grant plus req and
// fifo_full, so there is no combinational path from req to grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ready,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in
);

  localparam int PTR_W = clog2(NUM_REQ);
  localparam int CNT_W = clog2(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   owner_q, owner_d;   // binary index mirroring grant_q
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [PTR_W-1:0]   owner_next_ptr;
  logic [PTR_W-1:0]   pick_start;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_valid;
  logic               owner_req;
  logic               accept;
  logic               burst_done;

  assign owner_next_ptr = (owner_q == PTR_LAST) ? '0 : owner_q + 1'b1;

  // In BUSY the picker is only consumed on release, where the search starts just
  // past the owner (the owner itself is still eligible, last in line).
  assign pick_start = (state_q == BUSY) ? owner_next_ptr : rr_ptr_q;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req_i   (req),
    .start_i (pick_start),
    .pick_o  (pick_onehot),
    .valid_o (pick_valid)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) begin
        pick_idx = PTR_W'(i);
      end
    end
  end

  assign owner_req  = req[owner_q];
  assign accept     = (state_q == BUSY) & owner_req & ~fifo_full & ~rst;
  // A full stall is neither an accept nor a drop, so it never ends the burst.
  assign burst_done = (state_q == BUSY) & (~owner_req | (accept & (cnt_q == CNT_LAST)));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          grant_d = pick_onehot;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (burst_done) begin
          rr_ptr_d = owner_next_ptr;
          cnt_d    = '0;
          if (pick_valid) begin
            // Hand straight over to the next owner without an idle bubble.
            grant_d = pick_onehot;
            owner_d = pick_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    ready        = '0;
    fifo_wr_en   = 1'b0;
    fifo_data_in = '0;
    if (state_q == BUSY) begin
      fifo_data_in = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
    end
    if (accept) begin
      ready      = grant_q;
      fifo_wr_en = 1'b1;
    end
  end

  assign fifo_cs = fifo_wr_en;
  assign grant   = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed self-checking bench for fifo_wr_arbiter with
// NUM_REQ=4, BURST_MAX=2, DATA_WIDTH=32. Each scenario task drives inputs just
// after a rising edge and checks outputs before the next one.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BM = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] ready;
  logic [NR-1:0] grant;
  logic          fifo_full;
  logic          fifo_cs;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .ready        (ready),
    .grant        (grant),
    .fifo_full    (fifo_full),
    .fifo_cs      (fifo_cs),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in)
  );

  // One line per accepted write.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      $display("write: t=%0t grant=%b ready=%b data=%h", $time, grant, ready, fifo_data_in);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [NR*DW-1:0] pack4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                             input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    req = '0;
    fifo_full = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'b1111;
    fifo_full = 1'b0;
    req_data = pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3);
    settle();
    checks++;
    if (ready !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_pre_edge: ready=%b wr_en=%b, required ready=0000 wr_en=0", ready, fifo_wr_en);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant !== 4'b0000 || ready !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_cs !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: grant=%b ready=%b wr_en=%b cs=%b, required all 0",
                 c, grant, ready, fifo_wr_en, fifo_cs);
      end
    end
    rst = 1'b0;
    settle();
    checks++;
    if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: grant=%b wr_en=%b, required 0000/0", grant, fifo_wr_en);
    end
    tick();
    checks++;
    if (grant !== 4'b0001 || ready !== 4'b0001 || fifo_wr_en !== 1'b1 || fifo_data_in !== 32'hA0) begin
      errors++;
      $display("FAIL reset_first_grant: grant=%b ready=%b wr_en=%b data=%h, required 0001/0001/1/000000a0",
               grant, ready, fifo_wr_en, fifo_data_in);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_data = pack4(32'hAAAA_0000, 32'hBBBB_0001, 32'h0000_0004, 32'hDDDD_0003);
    req = 4'b0100;
    settle();
    checks++;
    if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: grant=%b wr_en=%b, required 0000/0", grant, fifo_wr_en);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (grant !== 4'b0100 || ready !== 4'b0100 || fifo_wr_en !== 1'b1 || fifo_data_in !== 32'h0000_0004) begin
        errors++;
        $display("FAIL single_beat %0d: grant=%b ready=%b wr_en=%b data=%h, required 0100/0100/1/00000004",
                 k, grant, ready, fifo_wr_en, fifo_data_in);
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] exp_g;
    logic [DW-1:0] exp_d;
    int exp_owner;
    apply_reset();
    req_data = pack4(32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003);
    req = 4'b1111;
    tick();
    for (int k = 0; k < 9; k++) begin
      exp_owner = (k / 2) % 4;
      exp_g = 4'b0001 << exp_owner;
      exp_d = 32'hC0DE_0000 + 32'(exp_owner);
      checks++;
      if (grant !== exp_g || ready !== exp_g || fifo_wr_en !== 1'b1 || fifo_data_in !== exp_d) begin
        errors++;
        $display("FAIL rr_cycle %0d: grant=%b ready=%b wr_en=%b data=%h, required %b/%b/1/%h",
                 k, grant, ready, fifo_wr_en, fifo_data_in, exp_g, exp_g, exp_d);
      end
      tick();
    end
    req = 4'b0000;
  endtask

  task automatic test_full_stall();
    apply_reset();
    req_data = pack4(32'h0, 32'h0000_0011, 32'h0, 32'h0000_0033);
    req = 4'b1010;
    tick();
    checks++;
    if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_data_in !== 32'h11 || dut.cnt_q !== 1'b0) begin
      errors++;
      $display("FAIL stall_first_beat: grant=%b wr_en=%b data=%h cnt=%b, required 0010/1/00000011/0",
               grant, fifo_wr_en, fifo_data_in, dut.cnt_q);
    end
    tick();
    fifo_full = 1'b1;
    settle();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ready !== 4'b0000 || fifo_wr_en !== 1'b0 || fifo_cs !== 1'b0 || grant !== 4'b0010 || dut.cnt_q !== 1'b1) begin
        errors++;
        $display("FAIL stall_cycle %0d: ready=%b wr_en=%b cs=%b grant=%b cnt=%b, required 0000/0/0/0010/1",
                 c, ready, fifo_wr_en, fifo_cs, grant, dut.cnt_q);
      end
      tick();
    end
    fifo_full = 1'b0;
    settle();
    checks++;
    if (ready !== 4'b0010 || fifo_wr_en !== 1'b1 || fifo_data_in !== 32'h11) begin
      errors++;
      $display("FAIL stall_resume: ready=%b wr_en=%b data=%h, required 0010/1/00000011",
               ready, fifo_wr_en, fifo_data_in);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || dut.cnt_q !== 1'b0 || dut.rr_ptr_q !== 2'd2 || fifo_data_in !== 32'h33) begin
      errors++;
      $display("FAIL stall_burst_end: grant=%b cnt=%b rr_ptr=%0d data=%h, required 1000/0/2/00000033",
               grant, dut.cnt_q, dut.rr_ptr_q, fifo_data_in);
    end
    req = 4'b0000;
  endtask

  task automatic test_early_drop();
    apply_reset();
    req_data = pack4(32'h0000_0100, 32'h0, 32'h0, 32'h0000_0333);
    req = 4'b1001;
    tick();
    checks++;
    if (grant !== 4'b0001 || ready !== 4'b0001 || fifo_data_in !== 32'h100) begin
      errors++;
      $display("FAIL drop_first_beat: grant=%b ready=%b data=%h, required 0001/0001/00000100",
               grant, ready, fifo_data_in);
    end
    tick();
    req = 4'b1000;
    settle();
    checks++;
    if (ready !== 4'b0000 || fifo_wr_en !== 1'b0 || grant !== 4'b0001) begin
      errors++;
      $display("FAIL drop_cycle: ready=%b wr_en=%b grant=%b, required 0000/0/0001", ready, fifo_wr_en, grant);
    end
    tick();
    checks++;
    if (grant !== 4'b1000 || dut.rr_ptr_q !== 2'd1 || ready !== 4'b1000 || fifo_data_in !== 32'h333) begin
      errors++;
      $display("FAIL drop_handoff: grant=%b rr_ptr=%0d ready=%b data=%h, required 1000/1/1000/00000333",
               grant, dut.rr_ptr_q, ready, fifo_data_in);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    req_data = pack4(32'h0, 32'h0000_5151, 32'h0, 32'h0);
    req = 4'b0010;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 4'b0010 || fifo_wr_en !== 1'b1 || dut.rr_ptr_q !== 2'd2) begin
      errors++;
      $display("FAIL midrst_before: grant=%b wr_en=%b rr_ptr=%0d, required 0010/1/2",
               grant, fifo_wr_en, dut.rr_ptr_q);
    end
    rst = 1'b1;
    settle();
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_cs !== 1'b0 || ready !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_no_write: wr_en=%b cs=%b ready=%b, required 0/0/0000", fifo_wr_en, fifo_cs, ready);
    end
    tick();
    checks++;
    if (dut.state_q !== 1'b0 || grant !== 4'b0000 || dut.rr_ptr_q !== 2'd0 || dut.cnt_q !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: state=%b grant=%b rr_ptr=%0d cnt=%b, required 0/0000/0/0",
               dut.state_q, grant, dut.rr_ptr_q, dut.cnt_q);
    end
    rst = 1'b0;
    req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    fifo_full = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_early_drop();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
